// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_prog family: pointer wrap, count-width
// derivation and the count update operation.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_prog: synchronous write, combinational read addressed by the
// read pointer. The array has no reset.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, exact occupancy and
// sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  af_thresh,
  input  logic [CNT_WIDTH-1:0]  ae_thresh,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic                  wr_acc, rd_acc, rd_adv;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
  cnt_op_e               cnt_op;

  assign wr_acc = we && !full_q;
  assign rd_acc = re && !empty_q;

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wptr_q),
    .wdata_i(data_in),
    .raddr_i(rptr_q),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    cnt_op = CNT_HOLD;
    if (wr_acc && !rd_acc) begin
      cnt_op = CNT_INC;
    end else if (rd_acc && !wr_acc) begin
      cnt_op = CNT_DEC;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (cnt_op)
      CNT_INC: count_d = count_q + CNT_WIDTH'(1);
      CNT_DEC: count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // count includes the prefetch word, so the array holds count minus that word.
  logic [CNT_WIDTH-1:0] ram_cnt;
  logic                 load;

  always_comb begin
    ram_cnt = count_q - CNT_WIDTH'(!empty_q);
    load    = (ram_cnt != '0) && (empty_q || rd_acc);
    rd_adv  = load;
    empty_d = !(load || (!empty_q && !rd_acc));
    dout_d  = load ? ram_rdata : dout_q;
  end
`else
  always_comb begin
    rd_adv  = rd_acc;
    empty_d = (count_d == '0);
    dout_d  = rd_acc ? ram_rdata : dout_q;
  end
`endif

  always_comb begin
    wptr_d = wr_acc ? ADDR_WIDTH'(next_ptr(32'(wptr_q), DEPTH)) : wptr_q;
    rptr_d = rd_adv ? ADDR_WIDTH'(next_ptr(32'(rptr_q), DEPTH)) : rptr_q;
    full_d = (count_d == CNT_WIDTH'(DEPTH));
    af_d   = (count_d >= af_thresh);
    ae_d   = (count_d <= ae_thresh);
    // A new offence wins over a simultaneous clear.
    ovf_d  = (we && full_q) || (ovf_q && !clr_err);
    udf_d  = (re && empty_q) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dout_q  <= dout_d;
    end
  end

  assign data_out     = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parameterised FIFO with programmable almost-full/almost-empty thresholds, occupancy count, sticky overflow/underflow error flags and optional first-word-fall-through (FWFT) output. It is the general-purpose buffering block for same-clock-domain paths, sitting beside the dual-clock FIFO. Unlike that block, it supports any integer depth (not only powers of two) and exposes exact occupancy.

## Interface
- DATA_WIDTH, 8, width of each data word.
- DEPTH, 16, number of storage words; any integer ≥ 2.
- Derived localparams: ADDR_WIDTH = $clog2(DEPTH); CNT_WIDTH = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- we  in  1  write request.
- re  in  1  read request (pop in FWFT mode).
- data_in  in  DATA_WIDTH  write data.
- af_thresh  in  CNT_WIDTH  almost-full threshold.
- ae_thresh  in  CNT_WIDTH  almost-empty threshold.
- clr_err  in  1  clears overflow/underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  no word available to read.
- almost_full  out  1  count ≥ af_thresh.
- almost_empty  out  1  count ≤ ae_thresh.
- count  out  CNT_WIDTH  words held, including any FWFT output word.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Write accepted iff we && !full. Read accepted iff re && !empty. No write-through when full, even with a simultaneous read.
- Both accepted: count unchanged, both pointers advance.
- Empty with we && re: write only; underflow sets.
- Full with we && re: read only; overflow sets.
- Pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- count is a register updated by +1, -1 or 0 per cycle. It never exceeds DEPTH and never goes below 0.
- All flags are registered and computed from next-state count.
  - almost_full and almost_empty use the current threshold inputs.
  - A threshold change is reflected one cycle later.
- overflow/underflow set on an offending request and stay set until clr_err. Set wins over clr_err in the same cycle.
- Standard mode: data_out is registered and loads mem[rptr] on an accepted read. It otherwise holds its value.
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, data_out 0.
- Reset mid-operation discards all contents. Memory is not cleared.

## Timing
- Standard mode:
  - Write accepted at edge N → empty low and count incremented after edge N.
  - Read accepted at edge M → data_out valid after edge M (latency 1).
- FWFT mode:
  - Write into an empty FIFO at edge N → head word on data_out and empty low after edge N+1.
  - Head word is presented when !empty. An accepted re at edge M presents the next word after edge M, with no bubble when more words are stored.
- full and almost_full assert after the edge on which the threshold-crossing write is accepted. They deassert after the edge on which the crossing read is accepted.
- Back-to-back reads and writes sustain one word per cycle in both modes.

## Configuration
- SYNC_FIFO_FWFT_EN defined: FWFT mode.
  - A prefetch output register holds the head word.
  - empty reflects the validity of that register.
  - The prefetch word counts toward count and full.
  - data_out stays at 0 until the first word arrives.
- Not defined: standard mode.
  - empty = (count == 0).
  - Read data appears one cycle after the accepted read.

## Structure
- Package sync_fifo_pkg holds:
  - function next_ptr(ptr, depth) for wrap-around increment.
  - function cnt_width(depth) returning $clog2(depth+1).
  - Shared enum for the count update op: CNT_HOLD, CNT_INC, CNT_DEC.
- Sub-module sync_fifo_ram: DEPTH×DATA_WIDTH array, synchronous write, read port addressed by rptr. No reset on the array.
- Pointers, count, flags, error logic and the FWFT register live in the top module.

## Test plan
- Reset, then write 0x01..0x10 with DEPTH=16 → full=1 and count=16 after the 16th write. A 17th write sets overflow=1; count stays 16. Readback in standard mode yields 0x01..0x10 in order, each one cycle after its re.
- DEPTH=5, 12 write/read cycles at full rate → pointers wrap 4→0 and data order is preserved. count oscillates within 0..5 and never exceeds 5.
- af_thresh=12, ae_thresh=3 → almost_full rises on the 12th word and almost_empty falls on the 4th word. Changing af_thresh to 8 with count=10 → almost_full=1 one cycle later.
- Empty FIFO with re=1 and we=1 in the same cycle → write accepted, underflow=1, count=1. clr_err in the same cycle as a new bad re → underflow remains 1.
- FWFT build: write 0xA5 into an empty FIFO → data_out=0xA5 and empty=0 two edges later. re pops it and empty returns to 1 with count=0.
- Assert rst mid-stream with count=7 → all outputs return to reset values immediately (asynchronously). The next write/read behave as for a fresh FIFO.
